wb_arbiter: RTL

// Collects completed results from the execution units that dispatch feeds
// (short ALU, long ALU, cache load, FPU) and serialises them onto the single

---
 rtl/wb_arbiter_if.sv | 28 ++
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-source result handshake in, single writeback port out.
// The arbiter uses the slave modport; the execution units (or a bench) use master.
interface wb_arbiter_if #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_ready;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC*REG_W-1:0]  src_rd;
  logic [N_SRC-1:0]        src_fpu;
  logic [DATA_W-1:0]       result_w;
  logic [REG_W-1:0]        rd_w;
  logic                    reg_write_w;
  logic                    fpu_reg_write_w;
  logic                    idle;

  modport slave (
    input  src_valid, src_data, src_rd, src_fpu,
    output src_ready, result_w, rd_w, reg_write_w, fpu_reg_write_w, idle
  );

  modport master (
    output src_valid, src_data, src_rd, src_fpu,
    input  src_ready, result_w, rd_w, reg_write_w, fpu_reg_write_w, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs drained one per cycle by a
// round-robin arbiter onto a registered int/FPU register-file write port.
module wb_arbiter #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic         clk,
  input  logic         rstn,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CAND_W = SRC_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              fpu;
  } entry_t;

  entry_t            r_mem  [N_SRC][DEPTH];
  logic [PTR_W-1:0]  r_wptr [N_SRC];
  logic [PTR_W-1:0]  r_rptr [N_SRC];
  logic [CNT_W-1:0]  r_cnt  [N_SRC];
  logic [SRC_W-1:0]  r_ptr;
  logic [N_SRC-1:0]  r_ready;
  logic [DATA_W-1:0] r_result;
  logic [REG_W-1:0]  r_rd;
  logic              r_reg_we;
  logic              r_fpu_we;
  logic              r_idle;

  logic [N_SRC-1:0]  w_push;
  logic [N_SRC-1:0]  w_pop;
  logic [CNT_W-1:0]  w_cnt_nxt [N_SRC];
  logic [CAND_W-1:0] w_cand;
  logic              w_gnt_vld;
  logic [SRC_W-1:0]  w_gnt_idx;
  entry_t            w_head;
  logic              w_reg_we_nxt;
  logic              w_fpu_we_nxt;
  logic              w_idle_nxt;

  // Round-robin search: first non-empty FIFO starting at r_ptr.
  always_comb begin : arb
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      w_cand = {1'b0, r_ptr} + CAND_W'(k);
      if (w_cand >= CAND_W'(N_SRC)) w_cand = w_cand - CAND_W'(N_SRC);
      if (!w_gnt_vld && (r_cnt[w_cand[SRC_W-1:0]] != '0)) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[SRC_W-1:0];
      end
    end
  end

  // Push is gated by the registered count only, so a full FIFO never takes
  // a push even on an edge where it is also popped.
  always_comb begin : fifo_ctl
    w_push = '0;
    w_pop  = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      w_push[i]    = bus.src_valid[i] && (r_cnt[i] != CNT_W'(DEPTH));
      w_pop[i]     = w_gnt_vld && (w_gnt_idx == SRC_W'(i));
      w_cnt_nxt[i] = r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
    end
  end

  always_comb begin : wb_nxt
    w_head       = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
    w_reg_we_nxt = w_gnt_vld && !w_head.fpu && (w_head.rd != '0);
    w_fpu_we_nxt = w_gnt_vld && w_head.fpu;
    w_idle_nxt   = !w_reg_we_nxt && !w_fpu_we_nxt;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (w_cnt_nxt[i] != '0) w_idle_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : state_q
    if (!rstn) begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_ptr    <= '0;
      r_ready  <= '1;
      r_result <= '0;
      r_rd     <= '0;
      r_reg_we <= 1'b0;
      r_fpu_we <= 1'b0;
      r_idle   <= 1'b1;
    end else begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        r_cnt[i]   <= w_cnt_nxt[i];
        r_ready[i] <= (w_cnt_nxt[i] != CNT_W'(DEPTH));
      end
      if (w_gnt_vld) begin
        r_ptr    <= (w_gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
        r_result <= w_head.data;
        r_rd     <= w_head.rd;
      end
      r_reg_we <= w_reg_we_nxt;
      r_fpu_we <= w_fpu_we_nxt;
      r_idle   <= w_idle_nxt;
    end
  end

  always_ff @(posedge clk) begin : fifo_mem
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= entry_t'({bus.src_data[i*DATA_W +: DATA_W],
                                         bus.src_rd[i*REG_W +: REG_W],
                                         bus.src_fpu[i]});
      end
    end
  end

  always_ff @(posedge clk) begin : occupancy_chk
    if (rstn) begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        assert (!(w_pop[i] && (r_cnt[i] == '0)));
        assert (r_cnt[i] <= CNT_W'(DEPTH));
      end
    end
  end

  assign bus.src_ready       = r_ready;
  assign bus.result_w        = r_result;
  assign bus.rd_w            = r_rd;
  assign bus.reg_write_w     = r_reg_we;
  assign bus.fpu_reg_write_w = r_fpu_we;
  assign bus.idle            = r_idle;

endmodule
